// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device command transmitter.
//
// Sends one command byte to a PS/2 device. The host inhibits the bus by holding
// the clock low, then drives the start bit and releases the clock. After that the
// device generates the clock and the host shifts out data, parity and stop bits.
// Finally the host samples the device's ack bit.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   reset        asynchronous active-low reset
//   wr_ps2       one-cycle request to send din (accepted only while idle)
//   din[7:0]     command byte
//   ps2c_in      raw PS/2 clock line level
//   ps2d_in      raw PS/2 data line level
//   ps2c_oe      1 = pull the clock line low
//   ps2d_oe      1 = pull the data line low
//   tx_idle      1 while no transfer is in progress
//   tx_done_tick one-cycle pulse at the end of every transfer, including timeouts
//   tx_err       1 = last transfer missed its ack or timed out; cleared by the next request
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus released, waiting for wr_ps2
// RTS      | clock held low for INHIBIT_CYC cycles, start bit set in the last cycle
// START    | clock released, start bit held, waiting for the first device clock
// DATA     | shifting out data bits LSB first, one per falling edge
// PARITY   | parity bit on the line
// STOP     | data released (stop bit), waiting for the ack clock edge
// ACK      | ack sampled, one cycle of settling
// WAITIDLE | waiting for the device to release both lines
module ps2_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC + 1) : 1;
    localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, RTS, START, DATA, PARITY, STOP, ACK, WAITIDLE
    } state_t;

    state_t                  state_q, state_d;
    logic                    c_s1_q, c_s1_d, c_s2_q, c_s2_d;
    logic                    d_s1_q, d_s1_d, d_s2_q, d_s2_d;
    logic [FILTER_LEN-1:0]   filt_sr_q, filt_sr_d;
    logic                    filt_q, filt_d;
    logic                    fall_q, fall_d;
    logic [7:0]              data_q, data_d;
    logic                    par_q, par_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [INH_W-1:0]        inh_q, inh_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    c_oe_q, c_oe_d;
    logic                    d_oe_q, d_oe_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    busy;

    always_comb begin
        c_s1_d    = ps2c_in;
        c_s2_d    = c_s1_q;
        d_s1_d    = ps2d_in;
        d_s2_d    = d_s1_q;
        filt_sr_d = {filt_sr_q[FILTER_LEN-2:0], c_s2_q};

        // Filtered clock only moves when every tap agrees.
        filt_d = filt_q;
        if (&filt_sr_q)
            filt_d = 1'b1;
        else if (~|filt_sr_q)
            filt_d = 1'b0;
        fall_d = filt_q & ~filt_d;

        state_d = state_q;
        data_d  = data_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        inh_d   = inh_q;
        c_oe_d  = c_oe_q;
        d_oe_d  = d_oe_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (wr_ps2) begin
                    data_d  = din;
                    par_d   = ~^din;
                    cnt_d   = 3'd0;
                    err_d   = 1'b0;
                    inh_d   = INH_W'(INHIBIT_CYC - 1);
                    c_oe_d  = 1'b1;
                    // A one-cycle inhibit has its start bit in that single cycle.
                    d_oe_d  = (INHIBIT_CYC <= 1);
                    state_d = RTS;
                end
            end
            RTS: begin
                if (inh_q == '0) begin
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b1;
                    state_d = START;
                end else begin
                    inh_d = inh_q - INH_W'(1);
                    if (inh_q == INH_W'(1))
                        d_oe_d = 1'b1;
                end
            end
            START: begin
                if (fall_q) begin
                    d_oe_d  = ~data_q[0];
                    data_d  = {1'b0, data_q[7:1]};
                    state_d = DATA;
                end
            end
            DATA: begin
                if (fall_q) begin
                    if (cnt_q == 3'd7) begin
                        cnt_d   = 3'd0;
                        d_oe_d  = ~par_q;
                        state_d = PARITY;
                    end else begin
                        cnt_d  = cnt_q + 3'd1;
                        d_oe_d = ~data_q[0];
                        data_d = {1'b0, data_q[7:1]};
                    end
                end
            end
            PARITY: begin
                if (fall_q) begin
                    d_oe_d  = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall_q) begin
                    if (d_s2_q)
                        err_d = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = WAITIDLE;
            end
            WAITIDLE: begin
                if (filt_q && d_s2_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy = (state_q != IDLE) && (state_q != RTS);
        if (busy && (wd_q == '0) && !fall_q && (state_d == state_q)) begin
            c_oe_d  = 1'b0;
            d_oe_d  = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
        end

        // Watchdog is a down-counter reloaded on any progress.
        wd_d = wd_q;
        if ((state_d != state_q) || fall_q)
            wd_d = WD_W'(TIMEOUT_CYC - 1);
        else if (wd_q != '0)
            wd_d = wd_q - WD_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            c_s1_q    <= 1'b0;
            c_s2_q    <= 1'b0;
            d_s1_q    <= 1'b0;
            d_s2_q    <= 1'b0;
            filt_sr_q <= '0;
            filt_q    <= 1'b1;
            fall_q    <= 1'b0;
            data_q    <= 8'h00;
            par_q     <= 1'b0;
            cnt_q     <= 3'd0;
            inh_q     <= '0;
            wd_q      <= '0;
            c_oe_q    <= 1'b0;
            d_oe_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_s1_q    <= c_s1_d;
            c_s2_q    <= c_s2_d;
            d_s1_q    <= d_s1_d;
            d_s2_q    <= d_s2_d;
            filt_sr_q <= filt_sr_d;
            filt_q    <= filt_d;
            fall_q    <= fall_d;
            data_q    <= data_d;
            par_q     <= par_d;
            cnt_q     <= cnt_d;
            inh_q     <= inh_d;
            wd_q      <= wd_d;
            c_oe_q    <= c_oe_d;
            d_oe_q    <= d_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ps2c_oe      = c_oe_q;
    assign ps2d_oe      = d_oe_q;
    assign tx_idle      = (state_q == IDLE);
    assign tx_done_tick = done_q;
    assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: drives ps2_tx against a behavioural PS/2 device on an open-collector bus.
// Expected results are queued when a request is issued. A monitor checks them at each
// tx_done_tick.
module tb_ps2_tx;

    localparam int INH = 5000;
    localparam int TMO = 3000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c = 1'b1;
    logic       dev_d = 1'b1;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err;

    assign ps2c_in = dev_c & ~ps2c_oe;
    assign ps2d_in = dev_d & ~ps2d_oe;

    always #5 clk = ~clk;

    ps2_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILTER_LEN(8)) dut (
        .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
        .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
        .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_err(tx_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        logic       p;
        logic       err;
        logic       full;
    } exp_t;
    exp_t sb[$];

    logic [7:0] rx_byte = 8'h00;
    logic       rx_par  = 1'b0;
    logic       rx_stop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic p, input logic err,
                        input logic full, input bit push);
        exp_t e;
        @(posedge clk); #1;
        din    = b;
        wr_ps2 = 1'b1;
        if (push) begin
            e.b = b; e.p = p; e.err = err; e.full = full;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        wr_ps2 = 1'b0;
        @(negedge clk);
        chk("err_cleared_on_request", tx_err, 0);
    endtask

    // Device side: measure the inhibit, then clock out nfall falling edges.
    task automatic dev_xfer(input int nfall, input bit ack, input bit glitch);
        int n;
        logic p_d, l_d;
        logic [10:0] bits;
        bits = '1;
        n = 0;
        while (ps2c_oe !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rts_started", ps2c_oe, 1);
        n = 0; p_d = 1'b0; l_d = 1'b0;
        while (ps2c_oe === 1'b1 && n < INH + 100) begin
            p_d = l_d;
            l_d = ps2d_oe;
            n++;
            @(negedge clk);
        end
        chk("rts_len", n, INH);
        chk("rts_last_cycle_data_low", l_d, 1);
        chk("rts_data_high_before_last", p_d, 0);
        chk("start_bit", ps2d_in, 0);
        repeat (H) @(negedge clk);
        for (int k = 1; k <= nfall; k++) begin
            dev_c = 1'b0;
            repeat (H) @(negedge clk);
            dev_c = 1'b1;
            if (k == 11) begin
                dev_d = 1'b1;
                break;
            end
            if (glitch && k == 3) begin
                repeat (12) @(negedge clk);
                dev_c = 1'b0;
                repeat (2) @(negedge clk);
                dev_c = 1'b1;
                repeat (H - 15) @(negedge clk);
            end else begin
                repeat (H - 1) @(negedge clk);
            end
            bits[k-1] = ps2d_in;
            if (k == 10 && ack) begin
                dev_d = 1'b0;
                repeat (2) @(negedge clk);
            end
        end
        rx_byte = bits[7:0];
        rx_par  = bits[8];
        rx_stop = bits[9];
    endtask

    task automatic wait_empty(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", sb.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_done_tick === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got tx_done_tick=1 expected no done");
                end else begin
                    e = sb.pop_front();
                    chk("tx_err", tx_err, e.err);
                    if (e.full) begin
                        chk("rx_byte", rx_byte, e.b);
                        chk("rx_parity", rx_par, e.p);
                        chk("rx_stop", rx_stop, 1);
                    end
                    @(negedge clk);
                    chk("done_one_cycle", tx_done_tick, 0);
                    chk("idle_after_done", tx_idle, 1);
                    chk("c_oe_after_done", ps2c_oe, 0);
                    chk("d_oe_after_done", ps2d_oe, 0);
                end
            end
        end
    end

    initial begin : main
        repeat (3) @(negedge clk);
        chk("rst_c_oe", ps2c_oe, 0);
        chk("rst_d_oe", ps2d_oe, 0);
        chk("rst_idle", tx_idle, 1);
        chk("rst_done", tx_done_tick, 0);
        chk("rst_err", tx_err, 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (40) @(negedge clk);

        // 0x07: three ones -> parity 0, acked
        fork
            send(8'h07, 1'b0, 1'b0, 1'b1, 1'b1);
            dev_xfer(11, 1'b1, 1'b0);
        join
        wait_empty(500);

        // 0xF4: five ones -> parity 0
        fork
            send(8'hF4, 1'b0, 1'b0, 1'b1, 1'b1);
            dev_xfer(11, 1'b1, 1'b0);
        join
        wait_empty(500);

        // 0x55: four ones -> parity 1, device never acks
        fork
            send(8'h55, 1'b1, 1'b1, 1'b1, 1'b1);
            dev_xfer(11, 1'b0, 1'b0);
        join
        wait_empty(500);
        chk("err_holds_after_nack", tx_err, 1);

        // 0xA5 with a clock glitch in DATA and a stray request while busy
        fork
            send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
            dev_xfer(11, 1'b1, 1'b1);
            begin
                repeat (INH + 150) @(posedge clk);
                #1 din = 8'h00; wr_ps2 = 1'b1;
                @(posedge clk); #1 wr_ps2 = 1'b0;
                @(negedge clk);
                chk("busy_request_ignored", tx_idle, 0);
            end
        join
        wait_empty(500);

        // device stops after bit 3 -> watchdog timeout
        fork
            send(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
            dev_xfer(4, 1'b1, 1'b0);
        join
        chk("no_done_before_timeout", tx_idle, 0);
        wait_empty(TMO + 500);

        // reset in the middle of DATA: no done expected
        fork
            send(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
            dev_xfer(5, 1'b1, 1'b0);
        join
        @(posedge clk); #2 reset = 1'b0;
        #1;
        chk("async_rst_c_oe", ps2c_oe, 0);
        chk("async_rst_d_oe", ps2d_oe, 0);
        chk("async_rst_idle", tx_idle, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        repeat (40) @(negedge clk);

        // 0xFF: eight ones -> parity 1
        fork
            send(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
            dev_xfer(11, 1'b1, 1'b0);
        join
        wait_empty(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter INHIBIT_CYC, default 5000, giving the host clock-low inhibit time in clk cycles (100 us at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1000000, giving the maximum clk cycles to wait for any expected device clock edge (20 ms).
REQ-003 The block SHALL have parameter FILTER_LEN, default 8, giving the ps2c glitch-filter depth in clk cycles.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-006 The block SHALL have port wr_ps2, input, 1, a one-cycle request to transmit din.
REQ-007 The block SHALL have port din, input, 8, the command byte to send to the device.
REQ-008 The block SHALL have port ps2c_in, input, 1, the raw PS/2 clock line level.
REQ-009 The block SHALL have port ps2d_in, input, 1, the raw PS/2 data line level.
REQ-010 The block SHALL have port ps2c_oe, output, 1; when it is 1 the top level drives the clock line low, otherwise the clock line is released (open-collector).
REQ-011 The block SHALL have port ps2d_oe, output, 1; when it is 1 the top level drives the data line low, otherwise the data line is released.
REQ-012 The block SHALL have port tx_idle, output, 1; it is 1 only in IDLE, and the top level gates the receiver's rx_en with it.
REQ-013 The block SHALL have port tx_done_tick, output, 1, a one-cycle pulse at the end of every transfer.
REQ-014 The block SHALL have port tx_err, output, 1, status for the last transfer: 1 = missing ack or timeout. It holds until the next accepted request.

Function
REQ-015 ps2c_in and ps2d_in SHALL each pass through a 2-FF synchronizer.
REQ-016 Synchronized ps2c SHALL feed a FILTER_LEN shift register. The filtered level changes only when all taps agree.
REQ-017 A falling-edge tick SHALL be a 1-cycle pulse, generated when the filtered clock goes from 1 to 0.
REQ-018 The FSM SHALL have states IDLE, RTS, START, DATA, PARITY, STOP, ACK, WAITIDLE.
REQ-019 In IDLE, wr_ps2=1 SHALL latch din into the shift register and compute the odd-parity bit (~^din).
  - The same request SHALL clear tx_err and the bit counter, and move the FSM to RTS.
  - wr_ps2 SHALL be ignored in every state other than IDLE.
REQ-020 RTS SHALL assert ps2c_oe=1 for exactly INHIBIT_CYC cycles. It SHALL assert ps2d_oe=1 (start bit = 0) in the last cycle of RTS, then go to START.
REQ-021 START SHALL release the clock (ps2c_oe=0) and hold ps2d_oe=1.
  - On the first falling tick the FSM SHALL drive bit 0 (ps2d_oe = ~bit) and go to DATA.
REQ-022 In DATA, each falling tick SHALL shift out the next bit, LSB first.
  - After the tick that follows the bit 7 drive, the FSM SHALL drive parity and go to PARITY.
  - Bit count SHALL be 8 data bits, wrapping exactly at 7.
REQ-023 In PARITY, the next falling tick SHALL release data (stop bit = 1) and go to STOP.
REQ-024 In STOP, the next falling tick SHALL sample the synchronized ps2d and go to ACK.
  - Sampled 0 = ack received; sampled 1 SHALL set tx_err=1.
REQ-025 ACK SHALL proceed to WAITIDLE in the following cycle.
REQ-026 WAITIDLE SHALL wait until the filtered clock and synchronized data are both 1. It SHALL then pulse tx_done_tick and return to IDLE.
REQ-027 A watchdog counter SHALL reset on every state change and every falling tick.
  - In START through WAITIDLE, reaching TIMEOUT_CYC SHALL release both lines, set tx_err=1, pulse tx_done_tick, and return to IDLE.
REQ-028 Data changes SHALL occur only in the cycle after a falling tick, never while the filtered clock is high.

Reset
REQ-029 While reset=0, the FSM SHALL be in IDLE.
  - Outputs: ps2c_oe=0, ps2d_oe=0, tx_idle=1, tx_done_tick=0, tx_err=0.
  - Internal state: shift register, counters and synchronizers = 0, filtered clock = 1.
REQ-030 Reset asserted mid-transfer SHALL release both lines asynchronously. No tx_done_tick SHALL be generated for the aborted transfer.

Verification
REQ-031 din=0x07, device model acks -> serial bits 1,1,1,0,0,0,0,0, parity 0, stop 1, ack sampled.
  - Required response: tx_done_tick once, tx_err=0.
REQ-032 din=0xF4 -> ps2c_oe high for exactly 5000 cycles, data low before clock release.
  - Bits LSB first, parity 0, tx_err=0.
REQ-033 din=0x55, device leaves data high at ack -> tx_done_tick, tx_err=1.
REQ-034 Device stops clocking after bit 3 -> after 1000000 cycles both oe=0, tx_err=1, tx_done_tick, tx_idle=1.
REQ-035 2-cycle glitch on ps2c during DATA -> no extra bit shifted, byte still correct.
  - Also: wr_ps2 while busy is ignored.
REQ-036 reset=0 asserted during DATA -> both oe=0 immediately, tx_idle=1.
  - After reset release, a new wr_ps2 with din=0xFF completes normally with parity 1.
